// File: rtl/triangle_raster_scan_if.sv
// Bundle between the triangle source, the raster scanner, the fill test and the pixel writer.
// master is the surrounding environment; slave is the scanner itself.
interface triangle_raster_scan_if;
  logic [2:0][2:0][15:0] tri_in;
  logic                  tri_valid;
  logic                  tri_ready;
  logic [11:0]           scan_hcount;
  logic [11:0]           scan_vcount;
  logic [2:0][2:0][15:0] scan_triangle;
  logic                  fill_is_within;
  logic                  frag_valid;
  logic [11:0]           frag_x;
  logic [11:0]           frag_y;
  logic                  tri_done;

  modport master (
    output tri_in, tri_valid, fill_is_within,
    input  tri_ready, scan_hcount, scan_vcount, scan_triangle,
           frag_valid, frag_x, frag_y, tri_done
  );

  modport slave (
    input  tri_in, tri_valid, fill_is_within,
    output tri_ready, scan_hcount, scan_vcount, scan_triangle,
           frag_valid, frag_x, frag_y, tri_done
  );
endinterface

// File: rtl/triangle_raster_scan.sv
// Accepts one screen-space triangle, scans its clamped bounding box in raster
// order and re-aligns the fill test's coverage result into registered fragments.
module triangle_raster_scan #(
  parameter int FILL_LATENCY = 3,
  parameter int H_MAX        = 1279,
  parameter int V_MAX        = 719
) (
  input logic                   clk,
  input logic                   rst,
  triangle_raster_scan_if.slave bus
);
  localparam int CW = $clog2(FILL_LATENCY + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BBOX  = 2'd1,
    SCAN  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  function automatic logic [11:0] min3(input logic [11:0] a, input logic [11:0] b,
                                       input logic [11:0] c);
    logic [11:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [11:0] max3(input logic [11:0] a, input logic [11:0] b,
                                       input logic [11:0] c);
    logic [11:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [11:0] clamp(input logic [11:0] v, input logic [11:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  state_t                state_r;
  logic                  tri_ready_r;
  logic [2:0][2:0][15:0] tri_r;
  logic [11:0]           x_r, y_r, xmin_r, xmax_r, ymax_r;
  logic [CW-1:0]         drain_cnt_r;
  logic [11:0]           bb_xmin_s, bb_xmax_s, bb_ymin_s, bb_ymax_s;
  logic                  issue_s, last_s;
  logic                  dl_issue_r [FILL_LATENCY];
  logic                  dl_last_r  [FILL_LATENCY];
  logic [11:0]           dl_x_r     [FILL_LATENCY];
  logic [11:0]           dl_y_r     [FILL_LATENCY];
  logic                  frag_valid_r, tri_done_r;
  logic [11:0]           frag_x_r, frag_y_r;

  // Clamped bounding box of the captured triangle; clamping keeps the scan counters from wrapping.
  always_comb begin
    bb_xmin_s = clamp(min3(tri_r[0][0][11:0], tri_r[1][0][11:0], tri_r[2][0][11:0]), 12'(H_MAX));
    bb_xmax_s = clamp(max3(tri_r[0][0][11:0], tri_r[1][0][11:0], tri_r[2][0][11:0]), 12'(H_MAX));
    bb_ymin_s = clamp(min3(tri_r[0][1][11:0], tri_r[1][1][11:0], tri_r[2][1][11:0]), 12'(V_MAX));
    bb_ymax_s = clamp(max3(tri_r[0][1][11:0], tri_r[1][1][11:0], tri_r[2][1][11:0]), 12'(V_MAX));
  end

  assign issue_s = (state_r == SCAN);
  assign last_s  = issue_s && (x_r == xmax_r) && (y_r == ymax_r);

  // Control FSM: capture, bbox, raster stepping and drain of the fill pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      tri_ready_r <= 1'b1;
      tri_r       <= '0;
      x_r         <= 12'd0;
      y_r         <= 12'd0;
      xmin_r      <= 12'd0;
      xmax_r      <= 12'd0;
      ymax_r      <= 12'd0;
      drain_cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.tri_valid && tri_ready_r) begin
            tri_r       <= bus.tri_in;
            tri_ready_r <= 1'b0;
            state_r     <= BBOX;
          end
        end
        BBOX: begin
          xmin_r  <= bb_xmin_s;
          xmax_r  <= bb_xmax_s;
          ymax_r  <= bb_ymax_s;
          x_r     <= bb_xmin_s;
          y_r     <= bb_ymin_s;
          state_r <= SCAN;
        end
        SCAN: begin
          // The final point stays on the scan outputs while the pipeline drains.
          if (x_r == xmax_r) begin
            if (y_r == ymax_r) begin
              drain_cnt_r <= '0;
              state_r     <= DRAIN;
            end else begin
              x_r <= xmin_r;
              y_r <= y_r + 12'd1;
            end
          end else begin
            x_r <= x_r + 12'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt_r == CW'(FILL_LATENCY)) begin
            tri_ready_r <= 1'b1;
            state_r     <= IDLE;
          end else begin
            drain_cnt_r <= drain_cnt_r + CW'(1);
          end
        end
        default: begin
          tri_ready_r <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  // Delay line matching the fill test latency, then the registered fragment stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FILL_LATENCY; i++) begin
        dl_issue_r[i] <= 1'b0;
        dl_last_r[i]  <= 1'b0;
        dl_x_r[i]     <= 12'd0;
        dl_y_r[i]     <= 12'd0;
      end
      frag_valid_r <= 1'b0;
      tri_done_r   <= 1'b0;
      frag_x_r     <= 12'd0;
      frag_y_r     <= 12'd0;
    end else begin
      dl_issue_r[0] <= issue_s;
      dl_last_r[0]  <= last_s;
      dl_x_r[0]     <= x_r;
      dl_y_r[0]     <= y_r;
      for (int i = 1; i < FILL_LATENCY; i++) begin
        dl_issue_r[i] <= dl_issue_r[i-1];
        dl_last_r[i]  <= dl_last_r[i-1];
        dl_x_r[i]     <= dl_x_r[i-1];
        dl_y_r[i]     <= dl_y_r[i-1];
      end
      frag_valid_r <= dl_issue_r[FILL_LATENCY-1] & bus.fill_is_within;
      tri_done_r   <= dl_issue_r[FILL_LATENCY-1] & dl_last_r[FILL_LATENCY-1];
      frag_x_r     <= dl_x_r[FILL_LATENCY-1];
      frag_y_r     <= dl_y_r[FILL_LATENCY-1];
    end
  end

  assign bus.tri_ready     = tri_ready_r;
  assign bus.scan_hcount   = x_r;
  assign bus.scan_vcount   = y_r;
  assign bus.scan_triangle = tri_r;
  assign bus.frag_valid    = frag_valid_r;
  assign bus.frag_x        = frag_x_r;
  assign bus.frag_y        = frag_y_r;
  assign bus.tri_done      = tri_done_r;
endmodule

// File: tb/tb_triangle_raster_scan.sv
// Self-checking bench for triangle_raster_scan with a behavioural three-stage fill test
// attached; expected fragments come from a direct bbox/coverage model of each triangle.
module tb_triangle_raster_scan;
  localparam int L  = 3;
  localparam int HM = 1279;
  localparam int VM = 719;

  typedef logic [2:0][2:0][15:0] tri_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   nf;
  int   bad_cnt;
  tri_t ta, tb2, tc;

  triangle_raster_scan_if ifc();

  triangle_raster_scan #(.FILL_LATENCY(L), .H_MAX(HM), .V_MAX(VM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  // Inclusive edge-function coverage test, either winding.
  function automatic bit covered(input int px, input int py, input tri_t t);
    int x0, y0, x1, y1, x2, y2, e0, e1, e2;
    x0 = int'(t[0][0][11:0]); y0 = int'(t[0][1][11:0]);
    x1 = int'(t[1][0][11:0]); y1 = int'(t[1][1][11:0]);
    x2 = int'(t[2][0][11:0]); y2 = int'(t[2][1][11:0]);
    e0 = (px - x0) * (y1 - y0) - (py - y0) * (x1 - x0);
    e1 = (px - x1) * (y2 - y1) - (py - y1) * (x2 - x1);
    e2 = (px - x2) * (y0 - y2) - (py - y2) * (x0 - x2);
    return (e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0);
  endfunction

  // Stand-in for triangle_2d_fill: three register stages, then the combinational sign test.
  logic [11:0] p_x [3] = '{default: 12'd0};
  logic [11:0] p_y [3] = '{default: 12'd0};
  tri_t        p_t [3] = '{default: '0};
  always @(posedge clk) begin
    p_x[0] <= ifc.scan_hcount;
    p_y[0] <= ifc.scan_vcount;
    p_t[0] <= ifc.scan_triangle;
    for (int i = 1; i < 3; i++) begin
      p_x[i] <= p_x[i-1];
      p_y[i] <= p_y[i-1];
      p_t[i] <= p_t[i-1];
    end
  end
  assign ifc.fill_is_within = covered(int'(p_x[2]), int'(p_y[2]), p_t[2]);

  function automatic tri_t mk_tri(input int x0, input int y0, input int x1, input int y1,
                                  input int x2, input int y2);
    tri_t t;
    t = '0;
    t[0][0][11:0] = 12'(x0); t[0][1][11:0] = 12'(y0);
    t[1][0][11:0] = 12'(x1); t[1][1][11:0] = 12'(y1);
    t[2][0][11:0] = 12'(x2); t[2][1][11:0] = 12'(y2);
    for (int v = 0; v < 3; v++) t[v][2] = 16'($urandom);
    return t;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One triangle end to end. Cycle 0 is the negedge right after the accept edge.
  task automatic run_tri(input string tag, input tri_t t, input bit predriven,
                         input bit chain, input tri_t t_next, output int nfrag);
    int vx[3], vy[3];
    int xmin, xmax, ymin, ymax, n, k, w;
    int ex_x[$], ex_y[$], ex_c[$];
    int got_x[$], got_y[$], got_c[$];
    int done_cnt, done_c, ready_c, unstable, oob;
    for (int v = 0; v < 3; v++) begin
      vx[v] = int'(t[v][0][11:0]);
      vy[v] = int'(t[v][1][11:0]);
    end
    xmin = vx[0]; xmax = vx[0]; ymin = vy[0]; ymax = vy[0];
    for (int v = 1; v < 3; v++) begin
      if (vx[v] < xmin) xmin = vx[v];
      if (vx[v] > xmax) xmax = vx[v];
      if (vy[v] < ymin) ymin = vy[v];
      if (vy[v] > ymax) ymax = vy[v];
    end
    if (xmin > HM) xmin = HM;
    if (xmax > HM) xmax = HM;
    if (ymin > VM) ymin = VM;
    if (ymax > VM) ymax = VM;
    n = (xmax - xmin + 1) * (ymax - ymin + 1);
    k = 0;
    for (int yy = ymin; yy <= ymax; yy++) begin
      for (int xx = xmin; xx <= xmax; xx++) begin
        if (covered(xx, yy, t)) begin
          ex_x.push_back(xx);
          ex_y.push_back(yy);
          ex_c.push_back(2 + k + L);
        end
        k++;
      end
    end

    if (!predriven) begin
      w = 0;
      while (ifc.tri_ready !== 1'b1 && w < 2000) begin
        @(negedge clk);
        w++;
      end
      check({tag, "_ready_wait"}, int'(ifc.tri_ready), 1);
      ifc.tri_in    = t;
      ifc.tri_valid = 1'b1;
    end
    @(negedge clk);
    check({tag, "_busy_after_accept"}, int'(ifc.tri_ready), 0);
    check({tag, "_captured"}, int'(ifc.scan_triangle === t), 1);
    if (chain) ifc.tri_in = t_next;
    else       ifc.tri_valid = 1'b0;

    done_cnt = 0; done_c = -1; ready_c = -1; unstable = 0; oob = 0;
    for (int c = 1; c <= n + L + 2; c++) begin
      @(negedge clk);
      if (ifc.frag_valid === 1'b1) begin
        got_x.push_back(int'(ifc.frag_x));
        got_y.push_back(int'(ifc.frag_y));
        got_c.push_back(c);
        if (ifc.frag_x > 12'd1279 || ifc.frag_y > 12'd719) oob++;
      end
      if (ifc.tri_done === 1'b1) begin
        done_cnt++;
        done_c = c;
      end
      if (ifc.tri_ready === 1'b1 && ready_c < 0) ready_c = c;
      if (ifc.scan_triangle !== t) unstable++;
    end

    check({tag, "_nfrag"}, got_x.size(), ex_x.size());
    for (int i = 0; i < got_x.size() && i < ex_x.size(); i++) begin
      check($sformatf("%s_frag%0d_x", tag, i), got_x[i], ex_x[i]);
      check($sformatf("%s_frag%0d_y", tag, i), got_y[i], ex_y[i]);
      check($sformatf("%s_frag%0d_cycle", tag, i), got_c[i], ex_c[i]);
    end
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_done_cycle"}, done_c, n + 1 + L);
    check({tag, "_ready_cycle"}, ready_c, n + 2 + L);
    check({tag, "_tri_stable"}, unstable, 0);
    check({tag, "_frag_in_range"}, oob, 0);
    nfrag = got_x.size();
  endtask

  initial begin
    ifc.tri_in    = '0;
    ifc.tri_valid = 1'b0;
    tc            = '0;

    // Reset and idle.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", int'(ifc.tri_ready), 1);
      check("idle_frag_valid", int'(ifc.frag_valid), 0);
      check("idle_tri_done", int'(ifc.tri_done), 0);
      check("idle_zero_outputs",
            int'(ifc.scan_hcount == 12'd0 && ifc.scan_vcount == 12'd0 &&
                 ifc.frag_x == 12'd0 && ifc.frag_y == 12'd0 && ifc.scan_triangle == '0), 1);
    end

    // Right triangle: 16 points, 10 fragments with x+y <= 3.
    ta = mk_tri(0, 0, 3, 0, 0, 3);
    run_tri("rt", ta, 1'b0, 1'b0, tc, nf);
    check("rt_ten_frags", nf, 10);

    // Single pixel.
    run_tri("px", mk_tri(5, 7, 5, 7, 5, 7), 1'b0, 1'b0, tc, nf);
    check("px_one_frag", nf, 1);

    // Bounding box clamped to the screen edge: 10 x 20 points.
    run_tri("clamp", mk_tri(1270, 700, 2000, 700, 1270, 900), 1'b0, 1'b0, tc, nf);

    // Two triangles queued back to back with tri_valid held high.
    ta  = mk_tri(10, 10, 16, 12, 11, 17);
    tb2 = mk_tri(40, 5, 34, 9, 44, 11);
    run_tri("chain_a", ta, 1'b0, 1'b1, tb2, nf);
    run_tri("chain_b", tb2, 1'b1, 1'b0, tc, nf);

    // Reset one cycle in the middle of a scan.
    ta = mk_tri(0, 0, 3, 0, 0, 3);
    ifc.tri_in    = ta;
    ifc.tri_valid = 1'b1;
    @(negedge clk);
    ifc.tri_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready_after_reset", int'(ifc.tri_ready), 1);
    bad_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (ifc.frag_valid !== 1'b0 || ifc.tri_done !== 1'b0) bad_cnt++;
    end
    check("abort_no_output", bad_cnt, 0);
    run_tri("fresh", ta, 1'b0, 1'b0, tc, nf);
    check("fresh_ten_frags", nf, 10);

    // Random small triangles, some straddling the right/bottom clamp.
    for (int r = 0; r < 6; r++) begin
      int bx, by;
      bx = int'($urandom_range(0, 1290));
      by = int'($urandom_range(0, 730));
      run_tri($sformatf("rnd%0d", r),
              mk_tri(bx + int'($urandom_range(0, 12)), by + int'($urandom_range(0, 12)),
                     bx + int'($urandom_range(0, 12)), by + int'($urandom_range(0, 12)),
                     bx + int'($urandom_range(0, 12)), by + int'($urandom_range(0, 12))),
              1'b0, 1'b0, tc, nf);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
